// File: rtl/a2910_pkg.sv
// a2910_pkg: shared constants for the a2910 microprogram sequencer.
// Holds the sixteen sequencer opcode encodings and the default address
// width / return-stack depth used by a2910_seq and a2910_stack.
package a2910_pkg;

  localparam int AW_DEF    = 12;
  localparam int DEPTH_DEF = 5;

  localparam logic [3:0] JZ   = 4'd0;
  localparam logic [3:0] CJS  = 4'd1;
  localparam logic [3:0] JMAP = 4'd2;
  localparam logic [3:0] CJP  = 4'd3;
  localparam logic [3:0] PUSH = 4'd4;
  localparam logic [3:0] JSRP = 4'd5;
  localparam logic [3:0] CJV  = 4'd6;
  localparam logic [3:0] JRP  = 4'd7;
  localparam logic [3:0] RFCT = 4'd8;
  localparam logic [3:0] RPCT = 4'd9;
  localparam logic [3:0] CRTN = 4'd10;
  localparam logic [3:0] CJPP = 4'd11;
  localparam logic [3:0] LDCT = 4'd12;
  localparam logic [3:0] LOOP = 4'd13;
  localparam logic [3:0] CONT = 4'd14;
  localparam logic [3:0] TWB  = 4'd15;

endpackage

// File: rtl/a2910_stack.sv
// a2910_stack: DEPTH x AW return-address stack with stack pointer.
// Ports:
//   CLK   - rising-edge clock
//   RST   - synchronous active-high reset (empties the stack)
//   push  - write din on top; when full, overwrites the top entry
//   pop   - drop top entry; no effect when empty
//   clear - empty the stack (SP <= 0)
//   din   - value to push
//   tos   - top entry; entry 0 (possibly stale) when empty
//   full  - high when DEPTH entries are held
module a2910_stack
  import a2910_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] tos,
  output logic          full
);

  localparam int             SPW    = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  logic [SPW-1:0] sp;
  logic [SPW-1:0] wr_idx;
  logic [SPW-1:0] rd_idx;
  logic [AW-1:0]  mem [DEPTH];

  assign full   = (sp == SP_MAX);
  // A push onto a full stack lands on the top slot instead of growing.
  assign wr_idx = full ? SP_MAX - SPW'(1) : sp;
  assign rd_idx = (sp == '0) ? '0 : sp - SPW'(1);
  assign tos    = mem[rd_idx];

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge CLK) begin
    if (RST || clear)
      sp <= '0;
    else if (push && !full)
      sp <= sp + SPW'(1);
    else if (pop && sp != '0)
      sp <= sp - SPW'(1);
  end

  // NOTE: the entries carry no reset; only SP defines what is valid, so
  // resetting the array would add a reset net to every bit for nothing.
  always_ff @(posedge CLK) begin
    if (push && !RST)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/a2910_seq.sv
// a2910_seq: microprogram sequencer feeding the a2901 microcode ROM.
// Each cycle selects the next microaddress from the uPC, D, the loop
// counter R or the return stack.
// Ports:
//   CLK, RST          - clock, synchronous active-high reset
//   I[3:0]            - sequencer opcode (see a2910_pkg)
//   D[AW-1:0]         - branch address / counter load value
//   CCbar, CCENbar    - condition code and condition enable (active low)
//   CI                - carry into the uPC incrementer
//   RLDbar            - load R from D, overriding opcode R activity
//   OEbar             - tri-states Y when high
//   Y[AW-1:0]         - next microaddress
//   FULLbar           - low when the return stack is full
//   PLbar/MAPbar/VECTbar - active-low enables for the D source
module a2910_seq
  import a2910_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [3:0]    I,
  input  logic [AW-1:0] D,
  input  logic          CCbar,
  input  logic          CCENbar,
  input  logic          CI,
  input  logic          RLDbar,
  input  logic          OEbar,
  output logic [AW-1:0] Y,
  output logic          FULLbar,
  output logic          PLbar,
  output logic          MAPbar,
  output logic          VECTbar
);

  logic [AW-1:0] upc;
  logic [AW-1:0] r;
  logic [AW-1:0] y_int;
  logic [AW-1:0] tos;
  logic          full;
  logic          pass;
  logic          rz;
  logic          stk_push;
  logic          stk_pop;
  logic          stk_clear;
  logic          r_load;
  logic          r_dec;

  assign pass = CCENbar | ~CCbar;
  assign rz   = (r == '0);

  // NOTE: every output of this block is given a default first so that no
  // opcode path leaves a signal unassigned and infers a latch.
  always_comb begin
    y_int     = upc;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;
    r_load    = 1'b0;
    r_dec     = 1'b0;
    unique case (I)
      JZ:   begin y_int = '0; stk_clear = 1'b1; end
      CJS:  if (pass) begin y_int = D; stk_push = 1'b1; end
      JMAP: y_int = D;
      CJP:  if (pass) y_int = D;
      PUSH: begin stk_push = 1'b1; r_load = pass; end
      JSRP: begin y_int = pass ? D : r; stk_push = 1'b1; end
      CJV:  if (pass) y_int = D;
      JRP:  y_int = pass ? D : r;
      RFCT: if (!rz) begin y_int = tos; r_dec = 1'b1; end
            else stk_pop = 1'b1;
      RPCT: if (!rz) begin y_int = D; r_dec = 1'b1; end
      CRTN: if (pass) begin y_int = tos; stk_pop = 1'b1; end
      CJPP: if (pass) begin y_int = D; stk_pop = 1'b1; end
      LDCT: r_load = 1'b1;
      LOOP: if (pass) stk_pop = 1'b1;
            else y_int = tos;
      CONT: y_int = upc;
      TWB: begin
        // Two-way branch: loop back to TOS while counting, exit via D on
        // count exhaustion, or fall through on PASS.
        if (pass) begin
          stk_pop = 1'b1;
          r_dec   = !rz;
        end else if (!rz) begin
          y_int = tos;
          r_dec = 1'b1;
        end else begin
          y_int   = D;
          stk_pop = 1'b1;
        end
      end
      default: y_int = upc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)
      upc <= '0;
    else
      upc <= y_int + AW'(CI);
  end

  // RLDbar wins over whatever the opcode asks of R.
  always_ff @(posedge CLK) begin
    if (RST)
      r <= '0;
    else if (!RLDbar || r_load)
      r <= D;
    else if (r_dec)
      r <= r - AW'(1);
  end

  a2910_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .CLK   (CLK),
    .RST   (RST),
    .push  (stk_push),
    .pop   (stk_pop),
    .clear (stk_clear),
    .din   (upc),
    .tos   (tos),
    .full  (full)
  );

  assign Y       = OEbar ? {AW{1'bz}} : y_int;
  assign FULLbar = ~full;
  assign PLbar   = (I == JMAP) || (I == CJV);
  assign MAPbar  = (I != JMAP);
  assign VECTbar = (I != CJV);

endmodule

// File: tb/tb_a2910_seq.sv
// tb_a2910_seq: directed scenarios followed by randomized opcodes, all
// checked against a queue-based behavioural model of the sequencer.
module tb_a2910_seq;
  import a2910_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 5;
  localparam int MASK  = (1 << AW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [3:0]    I = CONT;
  logic [AW-1:0] D = '0;
  logic          CCbar = 1'b1;
  logic          CCENbar = 1'b1;
  logic          CI = 1'b0;
  logic          RLDbar = 1'b1;
  logic          OEbar = 1'b0;
  logic [AW-1:0] Y;
  logic          FULLbar;
  logic          PLbar;
  logic          MAPbar;
  logic          VECTbar;

  int total = 0;
  int bad   = 0;

  a2910_seq #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .I       (I),
    .D       (D),
    .CCbar   (CCbar),
    .CCENbar (CCENbar),
    .CI      (CI),
    .RLDbar  (RLDbar),
    .OEbar   (OEbar),
    .Y       (Y),
    .FULLbar (FULLbar),
    .PLbar   (PLbar),
    .MAPbar  (MAPbar),
    .VECTbar (VECTbar)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  int            m_upc = 0;
  int            m_r   = 0;
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] m_slot0 = '0;
  bit            m_slot0_ok = 1'b0;

  logic [AW-1:0] e_y;
  bit            e_y_ok;
  bit            e_push, e_pop, e_clr, e_rld, e_rdec;

  task automatic check(input string tag, input logic [AW-1:0] obs,
                       input logic [AW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decide the next address and side effects from the current inputs.
  task automatic model_eval();
    bit            pass;
    bit            cnt_done;
    logic [AW-1:0] top;
    bit            top_ok;
    pass     = CCENbar || !CCbar;
    cnt_done = (m_r == 0);
    top_ok   = (m_q.size() > 0) || m_slot0_ok;
    top      = (m_q.size() > 0) ? m_q[$] : m_slot0;
    e_y = AW'(m_upc); e_y_ok = 1'b1;
    e_push = 0; e_pop = 0; e_clr = 0; e_rld = 0; e_rdec = 0;
    case (I)
      JZ:   begin e_y = '0; e_clr = 1; end
      CJS:  if (pass) begin e_y = D; e_push = 1; end
      JMAP: e_y = D;
      CJP:  if (pass) e_y = D;
      PUSH: begin e_push = 1; e_rld = pass; end
      JSRP: begin e_y = pass ? D : AW'(m_r); e_push = 1; end
      CJV:  if (pass) e_y = D;
      JRP:  e_y = pass ? D : AW'(m_r);
      RFCT: if (!cnt_done) begin e_y = top; e_y_ok = top_ok; e_rdec = 1; end
            else e_pop = 1;
      RPCT: if (!cnt_done) begin e_y = D; e_rdec = 1; end
      CRTN: if (pass) begin e_y = top; e_y_ok = top_ok; e_pop = 1; end
      CJPP: if (pass) begin e_y = D; e_pop = 1; end
      LDCT: e_rld = 1;
      LOOP: if (pass) e_pop = 1;
            else begin e_y = top; e_y_ok = top_ok; end
      CONT: ;
      default: begin // TWB
        if (pass) begin e_pop = 1; e_rdec = !cnt_done; end
        else if (!cnt_done) begin e_y = top; e_y_ok = top_ok; e_rdec = 1; end
        else begin e_y = D; e_pop = 1; end
      end
    endcase
  endtask

  task automatic model_commit();
    if (RST) begin
      m_upc = 0;
      m_r   = 0;
      m_q.delete();
    end else begin
      if (e_push) begin
        if (m_q.size() == DEPTH) m_q[$] = AW'(m_upc);
        else m_q.push_back(AW'(m_upc));
      end
      if (e_pop && m_q.size() > 0) void'(m_q.pop_back());
      if (e_clr) m_q.delete();
      if (!RLDbar || e_rld) m_r = int'(D);
      else if (e_rdec) m_r = m_r - 1;
      m_upc = (int'(e_y) + int'(CI)) & MASK;
    end
    if (m_q.size() > 0) begin
      m_slot0    = m_q[0];
      m_slot0_ok = 1'b1;
    end
  endtask

  // Apply inputs away from the clock edge, then compare against the model.
  task automatic drive(input logic [3:0] op, input logic [AW-1:0] d,
                       input bit ccb, input bit ccenb, input bit ci,
                       input bit rldb, input bit oeb, input bit rst);
    @(negedge CLK);
    I = op; D = d; CCbar = ccb; CCENbar = ccenb; CI = ci;
    RLDbar = rldb; OEbar = oeb; RST = rst;
    #1;
    model_eval();
    if (!rst) begin
      if (!oeb && e_y_ok) check("y_model", Y, e_y);
      check("pl_model",   AW'(PLbar),   AW'(op == JMAP || op == CJV));
      check("map_model",  AW'(MAPbar),  AW'(op != JMAP));
      check("vect_model", AW'(VECTbar), AW'(op != CJV));
      check("full_model", AW'(FULLbar), AW'(m_q.size() != DEPTH));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_commit();
  endtask

  // Shorthand: ccb=0/ccenb=0 is PASS, ccb=1/ccenb=0 is the failing case.
  initial begin
    // Reset, then count up with CONT.
    drive(CONT, '0, 1, 1, 0, 1, 0, 1); tick();
    RST = 1'b0;
    drive(CONT, '0, 1, 1, 1, 1, 0, 0);
    check("rst_y", Y, 12'h000);
    check("rst_full", AW'(FULLbar), AW'(1));
    check("rst_pl", AW'(PLbar), AW'(0));
    check("rst_map", AW'(MAPbar), AW'(1));
    check("rst_vect", AW'(VECTbar), AW'(1));
    tick();
    for (int k = 1; k < 4; k++) begin
      drive(CONT, '0, 1, 1, 1, 1, 0, 0);
      check("cont_y", Y, AW'(k));
      check("cont_full", AW'(FULLbar), AW'(1));
      tick();
    end

    // Subroutine call from address 0x010 and return to 0x011.
    drive(CJP, 12'h010, 0, 0, 1, 1, 0, 0); check("cjp_y", Y, 12'h010); tick();
    drive(CJS, 12'h200, 0, 0, 1, 1, 0, 0); check("cjs_y", Y, 12'h200); tick();
    drive(CRTN, '0, 0, 0, 1, 1, 0, 0);     check("crtn_y", Y, 12'h011); tick();

    // Counted loop with RPCT.
    drive(CJP, 12'h020, 0, 0, 0, 1, 0, 0); tick();
    drive(LDCT, 12'h003, 1, 0, 1, 1, 0, 0); check("ldct_y", Y, 12'h020); tick();
    for (int k = 0; k < 3; k++) begin
      drive(RPCT, 12'h020, 1, 0, 1, 1, 0, 0); check("rpct_loop_y", Y, 12'h020); tick();
    end
    drive(RPCT, 12'h020, 1, 0, 1, 1, 0, 0); check("rpct_exit_y", Y, 12'h021); tick();

    // Fill the stack past its depth, then drain it and pop once more.
    drive(CJP, 12'h0A0, 0, 0, 0, 1, 0, 0); tick();
    for (int k = 0; k < 6; k++) begin
      drive(PUSH, '0, 1, 1, 1, 1, 0, 0);
      check("push_y", Y, AW'(12'h0A0 + k));
      if (k == 5) check("push_full", AW'(FULLbar), AW'(0));
      tick();
    end
    drive(CRTN, '0, 0, 0, 0, 1, 0, 0);
    check("pop_full", AW'(FULLbar), AW'(0));
    check("pop_top", Y, 12'h0A5);
    tick();
    for (int k = 3; k >= 0; k--) begin
      drive(CRTN, '0, 0, 0, 0, 1, 0, 0);
      check("pop_y", Y, AW'(12'h0A0 + k));
      check("pop_notfull", AW'(FULLbar), AW'(1));
      tick();
    end
    drive(CRTN, '0, 0, 0, 0, 1, 0, 0); check("pop_empty_y", Y, 12'h0A0); tick();

    // Vector / map enables and output disable.
    drive(CJV, 12'h040, 0, 0, 1, 1, 0, 0);
    check("cjv_y", Y, 12'h040);
    check("cjv_vect", AW'(VECTbar), AW'(0));
    check("cjv_pl", AW'(PLbar), AW'(1));
    tick();
    drive(JMAP, 12'h123, 1, 0, 1, 1, 0, 0);
    check("jmap_y", Y, 12'h123);
    check("jmap_map", AW'(MAPbar), AW'(0));
    check("jmap_pl", AW'(PLbar), AW'(1));
    tick();
    drive(CONT, '0, 1, 1, 1, 1, 1, 0);
    check("oe_y_off", AW'(Y === 12'h124), AW'(0));
    tick();
    drive(CONT, '0, 1, 1, 1, 1, 0, 0); check("oe_advance", Y, 12'h125); tick();

    // Two-way branch with R counting down to zero.
    drive(CJP, 12'h050, 0, 0, 0, 1, 0, 0); tick();
    drive(PUSH, 12'h002, 1, 1, 1, 1, 0, 0); tick();
    drive(TWB, 12'h300, 1, 0, 1, 1, 0, 0); check("twb_r2", Y, 12'h050); tick();
    drive(TWB, 12'h300, 1, 0, 1, 1, 0, 0); check("twb_r1", Y, 12'h050); tick();
    drive(TWB, 12'h300, 1, 0, 1, 1, 0, 0); check("twb_r0", Y, 12'h300); tick();

    // RLDbar reload during RFCT suppresses the decrement.
    drive(CJP, 12'h070, 0, 0, 0, 1, 0, 0); tick();
    drive(PUSH, 12'h005, 1, 1, 1, 1, 0, 0); tick();
    drive(RFCT, 12'h002, 1, 0, 1, 0, 0, 0); check("rfct_rld", Y, 12'h070); tick();
    drive(RFCT, '0, 1, 0, 1, 1, 0, 0);      check("rfct_r2", Y, 12'h070); tick();
    drive(RFCT, '0, 1, 0, 1, 1, 0, 0);      check("rfct_r1", Y, 12'h070); tick();
    drive(RFCT, '0, 1, 0, 1, 1, 0, 0);      check("rfct_exit", Y, 12'h071); tick();

    // Randomized opcodes against the model.
    for (int n = 0; n < 800; n++) begin
      drive(4'($urandom_range(0, 15)), AW'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 49) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
